// File: rtl/reg_writeback_ctrl.sv
// MEM/WB writeback stage and register-file write initiator: clears every register after reset, then retires instructions.
// Optional macro REG_WB_FWD_EN adds the fwd_valid/fwd_reg/fwd_data bypass outputs.
module reg_writeback_ctrl #(
    parameter int                 NUM_REGS   = 32,
    parameter int                 ADDR_W     = 5,
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [ADDR_W-1:0] in_reg_dst,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              stall,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              regWrite,
    output logic              init_done
`ifdef REG_WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    // One extra count value marks the cycle after the last clear write.
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   init_cnt, init_cnt_nxt;
    logic [ADDR_W-1:0]  wb_reg_p1, wb_reg_nxt;
    logic [DATA_W-1:0]  wb_data_p1, wb_data_nxt;
    logic               vld_p1, vld_nxt;
    logic               init_done_p1, init_done_nxt;
    logic               accept;

    function automatic logic [DATA_W-1:0] wb_select(input logic              mem_to_reg,
                                                    input logic [DATA_W-1:0] mem_data,
                                                    input logic [DATA_W-1:0] alu_result);
        return mem_to_reg ? mem_data : alu_result;
    endfunction

    assign in_ready = (state == S_RUN) & ~stall;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_INIT;
            init_cnt     <= '0;
            wb_reg_p1    <= '0;
            wb_data_p1   <= '0;
            vld_p1       <= 1'b0;
            init_done_p1 <= 1'b0;
        end else begin
            state        <= state_nxt;
            init_cnt     <= init_cnt_nxt;
            wb_reg_p1    <= wb_reg_nxt;
            wb_data_p1   <= wb_data_nxt;
            vld_p1       <= vld_nxt;
            init_done_p1 <= init_done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        if (state == S_INIT) begin
            if (init_cnt < CNT_W'(NUM_REGS))
                init_cnt_nxt = init_cnt + 1'b1;
            else
                state_nxt = S_RUN;
        end
    end

    always_comb begin
        wb_reg_nxt    = wb_reg_p1;
        wb_data_nxt   = wb_data_p1;
        vld_nxt       = 1'b0;
        init_done_nxt = init_done_p1;
        case (state)
            S_INIT: begin
                if (init_cnt < CNT_W'(NUM_REGS)) begin
                    vld_nxt     = 1'b1;
                    wb_reg_nxt  = ADDR_W'(init_cnt);
                    wb_data_nxt = INIT_VALUE;
                end else begin
                    init_done_nxt = 1'b1;
                end
            end
            default: begin
                // $zero is never written once running.
                if (accept) begin
                    wb_reg_nxt  = in_reg_dst;
                    wb_data_nxt = wb_select(in_mem_to_reg, in_mem_data, in_alu_result);
                    vld_nxt     = in_reg_write & (in_reg_dst != '0);
                end
            end
        endcase
    end

    // ---- stage p1: registered write port ----
    assign write_reg  = wb_reg_p1;
    assign write_data = wb_data_p1;
    assign regWrite   = vld_p1;
    assign init_done  = init_done_p1;

`ifdef REG_WB_FWD_EN
    assign fwd_valid = vld_p1 & init_done_p1;
    assign fwd_reg   = wb_reg_p1;
    assign fwd_data  = wb_data_p1;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: expected writes are queued at stimulus time and
// popped by an independent monitor whenever the DUT asserts regWrite.
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_reg_write, in_mem_to_reg, stall;
    logic [4:0]  in_reg_dst, write_reg;
    logic [31:0] in_alu_result, in_mem_data, write_data;
    logic        regWrite, init_done;

    typedef struct packed { logic [4:0] r; logic [31:0] d; } wr_t;
    wr_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    reg_writeback_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_reg_dst(in_reg_dst), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .stall(stall),
        .write_reg(write_reg), .write_data(write_data),
        .regWrite(regWrite), .init_done(init_done)
    );

    // Register file the DUT drives; it has no reset of its own.
    always @(posedge clk) if (regWrite) rf[write_reg] <= write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every write the DUT presents must match the head of the queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (regWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_reg", {27'd0, write_reg}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_reg", {27'd0, write_reg}, {27'd0, e.r});
                    chk("write_data", write_data, e.d);
                end
            end
        end
    end

    task automatic push_init(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{r: 5'(i), d: 32'd0});
    endtask

    task automatic send(input logic [4:0] dst, input logic we, input logic m2r,
                        input logic [31:0] alu, input logic [31:0] mem);
        in_valid = 1'b1; in_reg_dst = dst; in_reg_write = we; in_mem_to_reg = m2r;
        in_alu_result = alu; in_mem_data = mem;
        if (we && dst != 5'd0) exp_q.push_back('{r: dst, d: (m2r ? mem : alu)});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("regWrite_after_accept", {31'd0, regWrite}, {31'd0, (we && dst != 5'd0)});
    endtask

    task automatic run_init_and_check(input string tag);
        repeat (32) @(posedge clk);
        #1 chk({tag, "_init_done_early"}, {31'd0, init_done}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
        chk({tag, "_regWrite_first_run"}, {31'd0, regWrite}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_init_q_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hBAD0_0000 | i;
        reset = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
        in_reg_dst = '0; in_alu_result = '0; in_mem_data = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);

        // Full clear sequence; in_valid is dropped while INIT runs.
        push_init(32);
        reset = 1'b0;
        in_valid = 1'b1; in_reg_write = 1'b1; in_reg_dst = 5'd9; in_alu_result = 32'h1111_1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("init_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (31) @(posedge clk);
        #1 chk("init_done_early", {31'd0, init_done}, 32'd0);
        @(posedge clk); #1;
        chk("init_done", {31'd0, init_done}, 32'd1);
        chk("regWrite_first_run", {31'd0, regWrite}, 32'd0);
        chk("in_ready_run", {31'd0, in_ready}, 32'd1);
        chk("rf31_cleared", rf[31], 32'd0);
        chk("rf9_cleared", rf[9], 32'd0);

        send(5'd1, 1'b1, 1'b0, 32'd55, 32'd0);
        chk("write_data_55", write_data, 32'd55);
        send(5'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);
        chk("rf1_55", rf[1], 32'd55);
        send(5'd2, 1'b1, 1'b1, 32'h0000_9999, 32'h0000_1234);

        // Stalled input must not be taken and must not disturb held outputs.
        stall = 1'b1; in_valid = 1'b1; in_reg_write = 1'b1; in_reg_dst = 5'd2;
        in_mem_to_reg = 1'b0; in_alu_result = 32'h0000_AAAA;
        #1 chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("stall_regWrite", {31'd0, regWrite}, 32'd0);
        chk("stall_hold_data", write_data, 32'h0000_1234);
        chk("stall_hold_reg", {27'd0, write_reg}, 32'd2);
        in_valid = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        chk("rf0_zero", rf[0], 32'd0);
        chk("rf2_1234", rf[2], 32'h0000_1234);

        // Back-to-back accepts, including a non-writing instruction.
        send(5'd3, 1'b1, 1'b0, 32'h0000_0003, 32'hFFFF_FFFF);
        send(5'd4, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h4444_0004);
        send(5'd6, 1'b0, 1'b0, 32'h6666_6666, 32'd0);
        send(5'd31, 1'b1, 1'b0, 32'h8000_0001, 32'd0);
        // Stall raised right after an accept: the presented write still lands.
        stall = 1'b1;
        @(posedge clk); #1;
        chk("stall_after_accept", {31'd0, regWrite}, 32'd0);
        stall = 1'b0;
        chk("rf31_written", rf[31], 32'h8000_0001);
        chk("rf6_untouched", rf[6], 32'd0);

        // Reset during INIT cycle 10 restarts the clear from address 0.
        reset = 1'b1;
        @(posedge clk); #1;
        push_init(10);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("midinit_rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("midinit_rst_init_done", {31'd0, init_done}, 32'd0);
        chk("midinit_q_drained", exp_q.size(), 32'd0);
        push_init(32);
        reset = 1'b0;
        run_init_and_check("restart");

        repeat (3) @(posedge clk);
        #1 chk("final_q_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
